// File: rtl/shift_pattern_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_pattern_gen_pkg : mode and FSM state encodings for the generator     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package shift_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_LFSR   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : shift_pattern_gen_pkg
`default_nettype wire

// File: rtl/shift_pattern_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_pattern_gen_if : control and pattern bus of the generator            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface shift_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic                        load;
  logic [WIDTH-1:0]            load_data;
  logic                        start;
  shift_pattern_gen_pkg::mode_t mode;
  logic [CNT_W-1:0]            burst_len;
  logic                        sin;
  logic                        D;
  logic [WIDTH-1:0]            q;
  logic                        busy;
  logic                        done;

  modport master (
    output load, load_data, start, mode, burst_len, sin,
    input  D, q, busy, done
  );

  modport slave (
    input  load, load_data, start, mode, burst_len, sin,
    output D, q, busy, done
  );

endinterface : shift_pattern_gen_if
`default_nettype wire

// File: rtl/shift_pattern_gen_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_pattern_gen_step : one combinational advance of the pattern register |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module shift_pattern_gen_step
  import shift_pattern_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_t            i_mode,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q_next
);

  logic [WIDTH-1:0] w_shl;

  assign w_shl = {i_q[WIDTH-2:0], 1'b0};

  always_comb begin
    o_q_next = i_q;
    case (i_mode)
      MODE_SHIFT:  o_q_next = {i_q[WIDTH-2:0], i_sin};
      MODE_ROTATE: o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      MODE_LFSR: begin
        // An all-zero Galois register would stick at zero; kick it to 1 instead.
        if (i_q == '0) begin
          o_q_next = WIDTH'(1);
        end else begin
          o_q_next = w_shl ^ (i_q[WIDTH-1] ? TAPS : '0);
        end
      end
      default:     o_q_next = i_q;
    endcase
  end

endmodule : shift_pattern_gen_step
`default_nettype wire

// File: rtl/shift_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | shift_pattern_gen : burst-controlled shift/rotate/LFSR pattern generator   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module shift_pattern_gen
  import shift_pattern_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               CNT_W = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D
) (
  input  logic               clk,
  input  logic               reset,
  shift_pattern_gen_if.slave bus
);

  state_t           r_state, w_state_nxt;
  mode_t            r_mode,  w_mode_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_q,     w_q_nxt;
  logic             r_done,  w_done_nxt;
  logic [WIDTH-1:0] w_q_step;

  shift_pattern_gen_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .i_q      (r_q),
    .i_mode   (r_mode),
    .i_sin    (bus.sin),
    .o_q_next (w_q_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_SHIFT;
      r_count <= '0;
      r_q     <= SEED;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_count <= w_count_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_count_nxt = r_count;
    w_q_nxt     = r_q;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load) begin
          w_q_nxt = bus.load_data;
        end else if (bus.start) begin
          // A zero-length burst completes immediately without touching q.
          if (bus.burst_len != '0) begin
            w_mode_nxt  = bus.mode;
            w_count_nxt = bus.burst_len;
            w_state_nxt = ST_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        w_q_nxt = w_q_step;
        if (r_count == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.q    = r_q;
  assign bus.D    = r_q[WIDTH-1];
  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = r_done;

endmodule : shift_pattern_gen
`default_nettype wire
